// File: rtl/park_core.sv
// Park / inverse-Park transform built on one shared DW x TW signed multiplier.
// Each transaction runs through four multiply steps, then rounds, shifts and saturates both results.
module park_core #(
    parameter int DW     = 16,
    parameter int TW     = 16,
    parameter int OSHIFT = 16,
    parameter int RND    = 1
) (
    input  logic                 rstn,
    input  logic                 clk,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_mode,
    input  logic signed [DW-1:0] i_x,
    input  logic signed [DW-1:0] i_y,
    input  logic signed [TW-1:0] i_sin,
    input  logic signed [TW-1:0] i_cos,
    output logic                 o_en,
    output logic signed [DW-1:0] o_a,
    output logic signed [DW-1:0] o_b,
    output logic [1:0]           o_sat
);

    localparam int PW  = DW + TW;
    localparam int AW  = PW + 1;
    localparam int RSH = (OSHIFT > 0) ? OSHIFT - 1 : 0;

    localparam logic signed [AW-1:0] RND_C   = (RND != 0 && OSHIFT > 0) ? (AW'(1) << RSH) : '0;
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M0   = 3'd1,
        S_M1   = 3'd2,
        S_M2   = 3'd3,
        S_M3   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic signed [DW-1:0]  x_q, x_d;
    logic signed [DW-1:0]  y_q, y_d;
    logic signed [TW-1:0]  sin_q, sin_d;
    logic signed [TW-1:0]  cos_q, cos_d;
    logic signed [AW-1:0]  acc0_q, acc0_d;
    logic signed [AW-1:0]  acc1_q, acc1_d;
    logic signed [DW-1:0]  o_a_q, o_a_d;
    logic signed [DW-1:0]  o_b_q, o_b_d;
    logic [1:0]            o_sat_q, o_sat_d;
    logic                  o_en_q, o_en_d;

    logic signed [DW-1:0]  mul_a;
    logic signed [TW-1:0]  mul_b;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  s1;
    logic signed [AW-1:0]  a_rnd, b_rnd;
    logic signed [AW-1:0]  a_sh, b_sh;

    function automatic logic sat_hit(input logic signed [AW-1:0] v);
        sat_hit = (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic signed [DW-1:0] sat_val(input logic signed [AW-1:0] v);
        if (v > SAT_MAX) begin
            sat_val = SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            sat_val = SAT_MIN[DW-1:0];
        end else begin
            sat_val = v[DW-1:0];
        end
    endfunction

    // Operand steering for the shared multiplier, one product per state.
    always_comb begin
        mul_a = x_q;
        mul_b = cos_q;
        case (state_q)
            S_M1: begin
                mul_a = y_q;
                mul_b = sin_q;
            end
            S_M2: begin
                mul_a = y_q;
                mul_b = cos_q;
            end
            S_M3: begin
                mul_a = x_q;
                mul_b = sin_q;
            end
            default: begin
                mul_a = x_q;
                mul_b = cos_q;
            end
        endcase
    end

    assign prod     = PW'(mul_a) * PW'(mul_b);
    assign prod_ext = AW'(prod);

    // Second result is finished combinationally in M3 and goes straight to rounding.
    assign s1    = mode_q ? (acc1_q + prod_ext) : (acc1_q - prod_ext);
    assign a_rnd = acc0_q + RND_C;
    assign b_rnd = s1 + RND_C;
    assign a_sh  = a_rnd >>> OSHIFT;
    assign b_sh  = b_rnd >>> OSHIFT;

    // Handshake: a transaction is taken on a rising clk edge where i_valid and o_ready are
    // both high; o_ready is a pure decode of the registered state (high only in IDLE).
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        acc0_d  = acc0_q;
        acc1_d  = acc1_q;
        o_a_d   = o_a_q;
        o_b_d   = o_b_q;
        o_sat_d = o_sat_q;
        o_en_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    mode_d  = i_mode;
                    x_d     = i_x;
                    y_d     = i_y;
                    sin_d   = i_sin;
                    cos_d   = i_cos;
                    acc0_d  = '0;
                    acc1_d  = '0;
                    state_d = S_M0;
                end
            end
            S_M0: begin
                acc0_d  = prod_ext;
                state_d = S_M1;
            end
            S_M1: begin
                acc0_d  = mode_q ? (acc0_q - prod_ext) : (acc0_q + prod_ext);
                state_d = S_M2;
            end
            S_M2: begin
                acc1_d  = prod_ext;
                state_d = S_M3;
            end
            S_M3: begin
                o_a_d   = sat_val(a_sh);
                o_b_d   = sat_val(b_sh);
                o_sat_d = {sat_hit(b_sh), sat_hit(a_sh)};
                o_en_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            acc0_q  <= '0;
            acc1_q  <= '0;
            o_a_q   <= '0;
            o_b_q   <= '0;
            o_sat_q <= '0;
            o_en_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            o_a_q   <= o_a_d;
            o_b_q   <= o_b_d;
            o_sat_q <= o_sat_d;
            o_en_q  <= o_en_d;
        end
    end

    assign o_ready = (state_q == S_IDLE);
    assign o_en    = o_en_q;
    assign o_a     = o_a_q;
    assign o_b     = o_b_q;
    assign o_sat   = o_sat_q;

endmodule
